rails_arbiter: RTL and testbench
================================

# rails_arbiter

Shares one rails stack-checker datapath between two upstream requesters. Each requester submits a frame: a header word N, then N coach words. The controller arbitrates round-robin and buffers the granted frame whole. It then streams the frame to the checker back-to-back, one word per cycle, captures the checker's verdict and returns it tagged with the requester id. It sits directly in front of the checker and owns its `data` input exclusively.

## Interface
- `MAX_N`, 10: largest legal coach count.
- `TIMEOUT`, 16: cycles to wait for `chk_valid` after the last coach; used only with `RAILS_ARB_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low.
- `req0_valid`, `req1_valid` in 1: requester word valid.
- `req0_data`, `req1_data` in 4: requester frame word.
- `req0_ready`, `req1_ready` out 1: word accepted when valid and ready are both high.
- `chk_data` out 4: drives checker `data`; 0 means idle/clear.
- `chk_valid` in 1: checker verdict valid.
- `chk_result` in 1: checker verdict, 1 = feasible.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_id` out 1: requester served.
- `rsp_result` out 1: verdict; forced to 0 when `rsp_err` is 1.
- `rsp_err` out 1: malformed frame or timeout.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- States: IDLE, COLLECT, BURST, WAIT, REPLY, FLUSH.
- IDLE: arbitrate.
  - If only one `reqX_valid` is high, grant that requester.
  - If both are high, grant the one not served last. `last_id` resets to 1, so req0 wins the first tie.
  - Next state is COLLECT.
- COLLECT: `reqG_ready`=1 and the other ready=0. Each accepted word is written to the frame buffer at `wptr`.
  - The first word is the header. If it is 0 or > MAX_N, set `err` and go to REPLY; the checker is never touched.
  - Each coach word that is 0 or > N sets `err`. The word is still consumed.
  - After coach N is accepted: go to REPLY if `err` is set, otherwise go to BURST.
- BURST: `chk_data` is registered from the buffer, one word per cycle: header, then coaches 1..N, with no gaps. After the last coach, go to WAIT.
- WAIT: `chk_data` holds the last coach. When `chk_valid`=1, capture `chk_result` and go to REPLY.
- REPLY: `rsp_valid`=1 for exactly one cycle, with `rsp_id`=G. Update `last_id`. Next state is FLUSH.
- FLUSH: `chk_data`=0 for exactly one cycle, which clears the checker. Then IDLE.
- Widths: `wptr`/`rptr` are 4 bits, max 11 entries; the coach count is 4 bits. No wrap-around is possible.
- Requester stalls inside COLLECT are tolerated without limit. The checker never sees a bubble, because BURST starts only after the whole frame is buffered.
- A `chk_valid` seen outside WAIT is ignored.
- Any non-granted `reqX_valid` stays pending with ready=0.

## Timing
- Reset values: `chk_data`=0, all `reqX_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_err`=0, `busy`=0, state IDLE.
- IDLE→COLLECT takes 1 cycle. The first ready is high the cycle after `req_valid` is seen in IDLE.
- A word accepted on cycle t is in the buffer at t+1.
- BURST: header on `chk_data` in the first BURST cycle; coach k at +k cycles.
- `rsp_valid` rises 1 cycle after `chk_valid` is sampled in WAIT.
- Minimum turnaround, legal frame of N coaches with zero stall and immediate verdict: 1 + (N+1) + (N+1) + 1 + 1 + 1 cycles.
- Reset asserted mid-operation: immediate return to reset values. Any partial frame is discarded and no response is issued.

## Configuration
- `RAILS_ARB_TIMEOUT_EN` defined:
  - WAIT counts cycles. On reaching TIMEOUT without `chk_valid`, go to REPLY with `rsp_err`=1 and `rsp_result`=0.
  - FLUSH still follows.
- Not defined: no counter; WAIT waits indefinitely for `chk_valid`.

## Structure
- `rails_pkg` holds:
  - state enum `rails_arb_state_e`
  - `RAILS_WORD_W`=4
  - `RAILS_MAX_N`=10
  - `RAILS_BUF_DEPTH`=MAX_N+1
- One sub-module, `rails_frame_buf`:
  - 11×4 register file
  - write port (`we`, `wptr`, `wdata`)
  - registered read at `rptr`
  - clear on reset only

## Test plan
- req0 sends 5,1,2,3,4,5, and the checker model returns result 1 → `rsp_valid` pulse with id 0, result 1, err 0. `chk_data` shows 5,1,2,3,4,5 on consecutive cycles, then holds 5, then shows 0 in FLUSH.
- Both requesters valid from reset with 3-coach frames → req0 is served first, then req1. Exactly two `rsp_valid` pulses, with ids 0 then 1.
- req1 header 0xB (> MAX_N) → `rsp_err`=1, `rsp_result`=0, id 1. `chk_data` stays 0 throughout.
- req0 sends 3,1,4,2 (coach 4 > N) → all 4 words consumed, err=1, no BURST.
- req0 stalls 7 cycles between coach words of the frame 4,4,3,2,1 → `chk_data` burst is still gap-free.
- With `RAILS_ARB_TIMEOUT_EN`, TIMEOUT=16, and the checker never asserting valid → `rsp_err`=1 exactly 16 cycles into WAIT. Separately, reset asserted mid-BURST → all outputs are 0 on the next edge.

Source files
------------

// File: rtl/rails_pkg.sv
// rails_pkg: shared sizes and state encoding for the rails arbiter slice
package rails_pkg;
  localparam int RAILS_WORD_W = 4;
  localparam int RAILS_MAX_N = 10;
  localparam int RAILS_BUF_DEPTH = RAILS_MAX_N + 1;
  typedef enum logic [2:0] {IDLE, COLLECT, BURST, WAIT, REPLY, FLUSH} rails_arb_state_e;
endpackage

// File: rtl/rails_frame_buf.sv
// rails_frame_buf: frame register file, one write port and a registered read port
module rails_frame_buf
  import rails_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [RAILS_WORD_W-1:0] wptr,
  input  logic [RAILS_WORD_W-1:0] wdata,
  input  logic [RAILS_WORD_W-1:0] rptr,
  output logic [RAILS_WORD_W-1:0] rdata
);
  logic [RAILS_WORD_W-1:0] mem [RAILS_BUF_DEPTH];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < RAILS_BUF_DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[wptr] <= wdata;
      rdata <= mem[rptr];
    end
endmodule

// File: rtl/rails_arbiter.sv
// rails_arbiter: round-robin front end sharing one rails checker between two requesters.
// Defining RAILS_ARB_TIMEOUT_EN adds a bounded wait for the checker verdict.
module rails_arbiter
  import rails_pkg::*;
#(
  parameter int MAX_N = RAILS_MAX_N
`ifdef RAILS_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  input  logic                    req1_valid,
  input  logic [RAILS_WORD_W-1:0] req0_data,
  input  logic [RAILS_WORD_W-1:0] req1_data,
  output logic                    req0_ready,
  output logic                    req1_ready,
  output logic [RAILS_WORD_W-1:0] chk_data,
  input  logic                    chk_valid,
  input  logic                    chk_result,
  output logic                    rsp_valid,
  output logic                    rsp_id,
  output logic                    rsp_result,
  output logic                    rsp_err,
  output logic                    busy
);
  localparam logic [RAILS_WORD_W-1:0] ONE = 1;
  rails_arb_state_e state, state_nx;
  logic g, last_id, err, result, acc, bad_hdr, bad_coach, to_hit;
  logic [RAILS_WORD_W-1:0] n, k, wptr, rptr, wdata, rdata;
  assign wdata = g ? req1_data : req0_data;
  assign req0_ready = state == COLLECT && !g;
  assign req1_ready = state == COLLECT && g;
  assign acc = g ? req1_valid && req1_ready : req0_valid && req0_ready;
  assign bad_hdr = wdata == '0 || wdata > RAILS_WORD_W'(MAX_N);
  assign bad_coach = wdata == '0 || wdata > n;
  // read one ahead so the header is already on rdata in the first BURST cycle
  assign rptr = state == BURST ? (k == n ? n : k + ONE) : (state == WAIT || state == REPLY) ? n : '0;
  // k stays 0 for frames rejected before BURST, keeping the checker input clear
  assign chk_data = (state == BURST || state == WAIT || (state == REPLY && k != '0)) ? rdata : '0;
  assign rsp_valid = state == REPLY;
  assign rsp_id = rsp_valid && g;
  assign rsp_err = rsp_valid && err;
  assign rsp_result = rsp_valid && result && !err;
  assign busy = state != IDLE;
  rails_frame_buf u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (acc),
    .wptr  (wptr),
    .wdata (wdata),
    .rptr  (rptr),
    .rdata (rdata)
  );
`ifdef RAILS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) tcnt <= '0;
    else tcnt <= state == WAIT ? tcnt + TW'(1) : '0;
  assign to_hit = tcnt == TW'(TIMEOUT - 1);
`else
  assign to_hit = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (req0_valid || req1_valid) ? COLLECT : IDLE;
      COLLECT: if (acc) state_nx = wptr == '0 ? (bad_hdr ? REPLY : COLLECT) :
                                   wptr == n ? ((err || bad_coach) ? REPLY : BURST) : COLLECT;
      BURST:   state_nx = k == n ? WAIT : BURST;
      WAIT:    state_nx = (chk_valid || to_hit) ? REPLY : WAIT;
      REPLY:   state_nx = FLUSH;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      g <= 1'b0;
      last_id <= 1'b1;
      err <= 1'b0;
      result <= 1'b0;
      n <= '0;
      k <= '0;
      wptr <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          g <= (req0_valid && req1_valid) ? !last_id : req1_valid;
          err <= 1'b0;
          result <= 1'b0;
          k <= '0;
          wptr <= '0;
        end
        COLLECT: if (acc) begin
          wptr <= wptr + ONE;
          n <= wptr == '0 ? wdata : n;
          err <= wptr == '0 ? bad_hdr : err || bad_coach;
        end
        BURST: k <= k + ONE;
        WAIT: begin
          result <= chk_valid ? chk_result : result;
          err <= err || (!chk_valid && to_hit);
        end
        REPLY: last_id <= g;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_rails_arbiter.sv
// tb_rails_arbiter: directed checks of arbitration, framing, burst timing and reset
module tb_rails_arbiter;
  logic clk = 0, reset = 0, req0_valid = 0, req1_valid = 0, chk_valid = 0, chk_result = 0;
  logic [3:0] req0_data = 0, req1_data = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy;
  logic [3:0] chk_data;
  int checks = 0, failures = 0;
  logic [3:0] q0[$], q1[$], trace[$], exp_q[$];
  int rsp_q[$];
  int c;
  always #5 clk = ~clk;
  rails_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_data  (req0_data),
    .req1_data  (req1_data),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .chk_data   (chk_data),
    .chk_valid  (chk_valid),
    .chk_result (chk_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );
  // response code: id*4 + result*2 + err
  always @(negedge clk) begin
    if (busy) trace.push_back(chk_data);
    if (rsp_valid) rsp_q.push_back(int'(rsp_id) * 4 + int'(rsp_result) * 2 + int'(rsp_err));
  end
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input bit id, input int stall);
    logic [3:0] w[$];
    int t;
    bit to;
    to = 0;
    if (id) w = q1; else w = q0;
    for (int i = 0; i < w.size(); i++) begin
      if (id) begin req1_valid = 1; req1_data = w[i]; end
      else begin req0_valid = 1; req0_data = w[i]; end
      t = 0;
      while (!(id ? req1_ready : req0_ready) && t < 400) begin @(posedge clk); #1; t++; end
      if (t >= 400) to = 1;
      @(posedge clk); #1;
      if (id) req1_valid = 0; else req0_valid = 0;
      if (stall > 0 && i >= 1 && i < w.size() - 1) repeat (stall) begin @(posedge clk); #1; end
    end
    check(id ? "req1_accept_stuck" : "req0_accept_stuck", int'(to), 0);
  endtask
  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 300) begin @(posedge clk); #1; t++; end
    check(tag, int'(busy), 0);
  endtask
  task automatic check_trace(input string tag);
    check({tag, "_len"}, trace.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_chk_data_%0d", tag, i), i < trace.size() ? int'(trace[i]) : -1, exp_q[i]);
  endtask
  task automatic check_outputs_zero(input string tag);
    check({tag, "_chk_data"}, chk_data, 0);
    check({tag, "_req0_ready"}, req0_ready, 0);
    check({tag, "_req1_ready"}, req1_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_result"}, rsp_result, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    #12;
    check_outputs_zero("reset");
    chk_valid = 1;
    chk_result = 1;
    q0 = '{4'd3, 4'd1, 4'd2, 4'd3};
    q1 = '{4'd3, 4'd3, 4'd2, 4'd1};
    fork
      send(0, 0);
      send(1, 0);
      begin @(posedge clk); #1; reset = 1; end
    join
    wait_idle("tie_idle");
    check("tie_rsp_count", rsp_q.size(), 2);
    check("tie_rsp_first", rsp_q.size() > 0 ? rsp_q[0] : -1, 2);
    check("tie_rsp_second", rsp_q.size() > 1 ? rsp_q[1] : -1, 6);
    trace.delete(); rsp_q.delete();
    q0 = '{4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    send(0, 0);
    wait_idle("t1_idle");
    exp_q = '{0, 0, 0, 0, 0, 0, 5, 1, 2, 3, 4, 5, 5, 5, 0};
    check_trace("t1");
    check("t1_rsp_count", rsp_q.size(), 1);
    check("t1_rsp", rsp_q.size() > 0 ? rsp_q[0] : -1, 2);
    trace.delete(); rsp_q.delete();
    q1 = '{4'd11};
    send(1, 0);
    wait_idle("hdr_idle");
    exp_q = '{0, 0, 0};
    check_trace("hdr");
    check("hdr_rsp_count", rsp_q.size(), 1);
    check("hdr_rsp", rsp_q.size() > 0 ? rsp_q[0] : -1, 5);
    trace.delete(); rsp_q.delete();
    q0 = '{4'd3, 4'd1, 4'd4, 4'd2};
    send(0, 0);
    wait_idle("coach_idle");
    exp_q = '{0, 0, 0, 0, 0, 0};
    check_trace("coach");
    check("coach_rsp_count", rsp_q.size(), 1);
    check("coach_rsp", rsp_q.size() > 0 ? rsp_q[0] : -1, 1);
    trace.delete(); rsp_q.delete();
    chk_result = 0;
    q0 = '{4'd4, 4'd4, 4'd3, 4'd2, 4'd1};
    send(0, 7);
    wait_idle("stall_idle");
    exp_q.delete();
    repeat (26) exp_q.push_back(0);
    exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(3); exp_q.push_back(2);
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
    check_trace("stall");
    check("stall_rsp_count", rsp_q.size(), 1);
    check("stall_rsp", rsp_q.size() > 0 ? rsp_q[0] : -1, 0);
    rsp_q.delete();
    chk_valid = 0;
    q0 = '{4'd2, 4'd1, 4'd2};
    send(0, 0);
`ifdef RAILS_ARB_TIMEOUT_EN
    c = 0;
    while (chk_data == 0 && c < 50) begin @(posedge clk); #1; c++; end
    c = 0;
    while (!rsp_valid && c < 50) begin @(posedge clk); #1; c++; end
    check("to_cycles", c, 19);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_result", rsp_result, 0);
    check("to_rsp_id", rsp_id, 0);
    wait_idle("to_idle");
`else
    repeat (40) begin @(posedge clk); #1; end
    check("wait_busy", busy, 1);
    check("wait_hold", chk_data, 2);
    check("wait_no_rsp", rsp_q.size(), 0);
    chk_valid = 1;
    chk_result = 1;
    @(posedge clk); #1;
    check("wait_rsp_valid", rsp_valid, 1);
    check("wait_rsp_id", rsp_id, 0);
    check("wait_rsp_err", rsp_err, 0);
    check("wait_rsp_result", rsp_result, 1);
    wait_idle("wait_idle");
`endif
    chk_valid = 1;
    chk_result = 1;
    rsp_q.delete();
    q0 = '{4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    send(0, 0);
    check("mid_hdr", chk_data, 5);
    repeat (2) begin @(posedge clk); #1; end
    check("mid_coach2", chk_data, 2);
    reset = 0;
    #1;
    check_outputs_zero("mid_async");
    @(posedge clk); #1;
    check_outputs_zero("mid_edge");
    reset = 1;
    repeat (20) begin @(posedge clk); #1; end
    check("mid_no_rsp", rsp_q.size(), 0);
    check("mid_idle", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
